change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Pays out change from the vending machine by driving a three-denomination coin hopper (Rs5, Rs2, Rs1). It accepts a change amount over a valid/ready handshake and issues one coin at a time, largest denomination first. Each coin is held until the hopper acknowledges it. The block tracks the coin inventory per denomination and raises a fault when it cannot complete a payout. It sits downstream of the money collector and is the counterpart that returns coins to the user.

Parameters:
AMT_W, 5, width of the change amount (max payout 31)
CNT_W, 4, width of each inventory counter
INIT_COUNT, 8, per-denomination coin count loaded at reset and on restock
GAP_CYCLES, 4, idle clk cycles enforced between successive coins (min 1)
ACK_TIMEOUT, 255, clk cycles to wait for hopper_ack before fault

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  change request present
req_amount  in  AMT_W  change to pay, in Rs
req_ready  out  1  block can accept a request; high only in IDLE
coin_sel  out  3  one-hot coin to eject (bit2=Rs5, bit1=Rs2, bit0=Rs1), zero when not issuing
coin_valid  out  1  coin_sel is valid; held until hopper_ack
hopper_ack  in  1  hopper has ejected the presented coin
restock  in  1  single-cycle pulse: reload inventory, clear fault
busy  out  1  payout in progress
done  out  1  one-cycle pulse when a payout completes
fault  out  1  sticky: payout impossible or hopper timeout
remaining  out  AMT_W  amount still owed in the current or faulted payout
cnt5, cnt2, cnt1  out  CNT_W each  current inventory

Behaviour:
- Reset (async): state IDLE, remaining=0, coin_sel=0, coin_valid=0, busy=0, done=0, fault=0, all cnt=INIT_COUNT. req_ready=1 because the state is IDLE.
- States: IDLE, SELECT, ISSUE, GAP, FAULT. All outputs are registered except req_ready, which is decoded from the state.
- IDLE: when req_valid & req_ready, capture remaining<=req_amount, set busy=1 and go to SELECT on the next edge.
- SELECT (1 cycle), greedy choice in this order:
  - remaining>=5 & cnt5>0: choose Rs5.
  - else remaining>=2 & cnt2>0: choose Rs2.
  - else remaining>=1 & cnt1>0: choose Rs1.
  - remaining==0: pulse done, busy=0, go to IDLE. A request of 0 gives done 2 cycles after acceptance and issues no coins.
  - otherwise (remaining>0 and no denomination fits): fault=1, go to FAULT. remaining is kept as the unpaid amount.
  - When a coin is chosen: drive coin_sel, set coin_valid=1, clear the timeout counter, go to ISSUE.
- ISSUE: hold coin_sel and coin_valid stable. On the cycle hopper_ack=1:
  - drop coin_valid and coin_sel;
  - decrement remaining by the coin value;
  - decrement the matching cnt;
  - go to GAP.
  - If the timeout counter reaches ACK_TIMEOUT with no ack: fault=1, coin_valid=0, go to FAULT. remaining and cnt are unchanged.
- hopper_ack outside ISSUE is ignored.
- GAP: count GAP_CYCLES cycles, then go to SELECT.
- Greedy is final. A payable amount can still fault: for example 6 with cnt1=0 pays Rs5, then faults with 1 owed. No backtracking.
- FAULT: busy=0, req_ready=0. Only restock or reset leaves this state. restock clears fault and remaining, reloads all cnt, and returns to IDLE.
- restock in IDLE reloads the inventory. restock in SELECT, ISSUE or GAP is ignored (the inventory must not change mid-payout).
- req_valid while not in IDLE is ignored; no request is queued.
- Arithmetic: remaining never underflows, because a coin is chosen only if it is <= remaining. cnt never underflows, because a coin is chosen only if its cnt>0.
- Reset mid-payout: the coin being presented is abandoned immediately (coin_valid=0), and all state returns to reset values.

Test Plan:
- Reset, req_amount=8 with ack 2 cycles after each coin_valid -> coin order Rs5, Rs2, Rs1; one done pulse; remaining=0; cnt5=cnt2=cnt1=7; coins separated by >=GAP_CYCLES.
- req_amount=0 -> no coin_valid; done 2 cycles after the handshake; inventory unchanged.
- Drain cnt1 to 0 (request 1 eight times), then request 6 -> Rs5 issued, then fault=1, remaining=1, req_ready=0. restock -> fault=0, all cnt=8, req_ready=1.
- Request 2, hold hopper_ack=0 -> after ACK_TIMEOUT cycles, fault=1 and coin_valid=0; remaining=2, cnt2 unchanged.
- Assert reset while coin_valid=1 during request 10 -> coin_valid, busy and remaining go to 0 without waiting for a clk edge; cnt values return to 8.
- Assert restock and a second req_valid during a payout -> both ignored: the inventory only decrements, and one done pulse matches the first request.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Request and coin-hopper signal bundle between the vending controller and the change dispenser.
interface change_dispenser_if #(
   parameter int unsigned AMT_W = 5,
   parameter int unsigned CNT_W = 4
);
   logic             req_valid;
   logic [AMT_W-1:0] req_amount;
   logic             req_ready;
   logic [2:0]       coin_sel;
   logic             coin_valid;
   logic             hopper_ack;
   logic             restock;
   logic             busy;
   logic             done;
   logic             fault;
   logic [AMT_W-1:0] remaining;
   logic [CNT_W-1:0] cnt5;
   logic [CNT_W-1:0] cnt2;
   logic [CNT_W-1:0] cnt1;

   // Dispenser side
   modport slave (
      input  req_valid, req_amount, hopper_ack, restock,
      output req_ready, coin_sel, coin_valid, busy, done, fault, remaining, cnt5, cnt2, cnt1
   );

   // Controller / hopper side
   modport master (
      output req_valid, req_amount, hopper_ack, restock,
      input  req_ready, coin_sel, coin_valid, busy, done, fault, remaining, cnt5, cnt2, cnt1
   );
endinterface

// File: rtl/change_dispenser.sv
// Greedy Rs5/Rs2/Rs1 change payout: one coin at a time, held until the hopper acks it,
// with per-denomination inventory and a sticky fault for unpayable amounts or hopper timeouts.
module change_dispenser #(
   parameter int unsigned AMT_W       = 5,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned INIT_COUNT  = 8,
   parameter int unsigned GAP_CYCLES  = 4,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input logic               clk,
   input logic               reset,
   change_dispenser_if.slave bus
);
   localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_COUNT);
   localparam logic [2:0] SEL5 = 3'b100;
   localparam logic [2:0] SEL2 = 3'b010;
   localparam logic [2:0] SEL1 = 3'b001;

   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_GAP, S_FAULT} state_t;

   state_t            r_state,     w_state;
   logic [AMT_W-1:0]  r_remaining, w_remaining;
   logic [2:0]        r_coin_sel,  w_coin_sel;
   logic              r_coin_valid, w_coin_valid;
   logic              r_busy,      w_busy;
   logic              r_done,      w_done;
   logic              r_fault,     w_fault;
   logic [CNT_W-1:0]  r_cnt5,      w_cnt5;
   logic [CNT_W-1:0]  r_cnt2,      w_cnt2;
   logic [CNT_W-1:0]  r_cnt1,      w_cnt1;
   logic [TO_W-1:0]   r_tcnt,      w_tcnt;
   logic [GAP_W-1:0]  r_gcnt,      w_gcnt;
   logic [AMT_W-1:0]  w_coin_val;

   // Value in Rs of the coin currently presented
   always_comb begin
      w_coin_val = '0;
      if (r_coin_sel[2])      w_coin_val = AMT_W'(5);
      else if (r_coin_sel[1]) w_coin_val = AMT_W'(2);
      else if (r_coin_sel[0]) w_coin_val = AMT_W'(1);
   end

   // State register and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_remaining  <= '0;
         r_coin_sel   <= '0;
         r_coin_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_fault      <= 1'b0;
         r_cnt5       <= INIT_CNT;
         r_cnt2       <= INIT_CNT;
         r_cnt1       <= INIT_CNT;
         r_tcnt       <= '0;
         r_gcnt       <= '0;
      end else begin
         r_state      <= w_state;
         r_remaining  <= w_remaining;
         r_coin_sel   <= w_coin_sel;
         r_coin_valid <= w_coin_valid;
         r_busy       <= w_busy;
         r_done       <= w_done;
         r_fault      <= w_fault;
         r_cnt5       <= w_cnt5;
         r_cnt2       <= w_cnt2;
         r_cnt1       <= w_cnt1;
         r_tcnt       <= w_tcnt;
         r_gcnt       <= w_gcnt;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      w_state      = r_state;
      w_remaining  = r_remaining;
      w_coin_sel   = r_coin_sel;
      w_coin_valid = r_coin_valid;
      w_busy       = r_busy;
      w_done       = 1'b0;
      w_fault      = r_fault;
      w_cnt5       = r_cnt5;
      w_cnt2       = r_cnt2;
      w_cnt1       = r_cnt1;
      w_tcnt       = r_tcnt;
      w_gcnt       = r_gcnt;

      unique case (r_state)
         S_IDLE: begin
            if (bus.restock) begin
               w_cnt5 = INIT_CNT;
               w_cnt2 = INIT_CNT;
               w_cnt1 = INIT_CNT;
            end
            if (bus.req_valid) begin
               w_remaining = bus.req_amount;
               w_busy      = 1'b1;
               w_state     = S_SELECT;
            end
         end
         S_SELECT: begin
            // Greedy, largest denomination first; no backtracking
            if (r_remaining >= AMT_W'(5) && r_cnt5 != '0) begin
               w_coin_sel = SEL5;
            end else if (r_remaining >= AMT_W'(2) && r_cnt2 != '0) begin
               w_coin_sel = SEL2;
            end else if (r_remaining >= AMT_W'(1) && r_cnt1 != '0) begin
               w_coin_sel = SEL1;
            end
            if (w_coin_sel != 3'b000) begin
               w_coin_valid = 1'b1;
               w_tcnt       = '0;
               w_state      = S_ISSUE;
            end else if (r_remaining == '0) begin
               w_done  = 1'b1;
               w_busy  = 1'b0;
               w_state = S_IDLE;
            end else begin
               w_fault = 1'b1;
               w_busy  = 1'b0;
               w_state = S_FAULT;
            end
         end
         S_ISSUE: begin
            if (bus.hopper_ack) begin
               w_coin_valid = 1'b0;
               w_coin_sel   = '0;
               w_remaining  = r_remaining - w_coin_val;
               if (r_coin_sel[2])      w_cnt5 = r_cnt5 - CNT_W'(1);
               else if (r_coin_sel[1]) w_cnt2 = r_cnt2 - CNT_W'(1);
               else                    w_cnt1 = r_cnt1 - CNT_W'(1);
               w_gcnt  = '0;
               w_state = S_GAP;
            end else if (r_tcnt == TO_W'(ACK_TIMEOUT - 1)) begin
               w_coin_valid = 1'b0;
               w_coin_sel   = '0;
               w_fault      = 1'b1;
               w_busy       = 1'b0;
               w_state      = S_FAULT;
            end else begin
               w_tcnt = r_tcnt + TO_W'(1);
            end
         end
         S_GAP: begin
            if (r_gcnt == GAP_W'(GAP_CYCLES - 1)) w_state = S_SELECT;
            else                                  w_gcnt  = r_gcnt + GAP_W'(1);
         end
         S_FAULT: begin
            if (bus.restock) begin
               w_fault     = 1'b0;
               w_remaining = '0;
               w_cnt5      = INIT_CNT;
               w_cnt2      = INIT_CNT;
               w_cnt1      = INIT_CNT;
               w_state     = S_IDLE;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   // Ready is the only combinational output
   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.coin_sel   = r_coin_sel;
   assign bus.coin_valid = r_coin_valid;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.fault      = r_fault;
   assign bus.remaining  = r_remaining;
   assign bus.cnt5       = r_cnt5;
   assign bus.cnt2       = r_cnt2;
   assign bus.cnt1       = r_cnt1;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy order, zero request, greedy fault,
// hopper timeout, async reset mid-coin, and ignored restock/request during payout.
module tb_change_dispenser;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   change_dispenser_if #(.AMT_W(5), .CNT_W(4)) bus ();

   change_dispenser #(
      .AMT_W(5), .CNT_W(4), .INIT_COUNT(8), .GAP_CYCLES(4), .ACK_TIMEOUT(255)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hopper-service results
   logic [2:0] coin_log[$];
   int         done_cnt;
   int         min_gap;
   int         hi_total;
   bit         svc_end;

   // Present one request for one cycle (block must be in IDLE)
   task automatic send_req(input logic [4:0] amt);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_amount = amt;
      @(negedge clk);
      bus.req_valid  = 1'b0;
   endtask

   // Hopper model: ack ack_delay samples after coin_valid rises (never if <0);
   // optionally pokes restock + a second request on iterations [poke_from, poke_to].
   task automatic service(input int ack_delay, input int budget, input int poke_from, input int poke_to);
      int hi;
      int lo;
      bit seen;
      coin_log.delete();
      done_cnt = 0; min_gap = 1000; hi_total = 0; svc_end = 1'b0;
      hi = 0; lo = 0; seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         bus.restock    = (c == poke_from);
         bus.req_valid  = (c >= poke_from && c <= poke_to && poke_from >= 0);
         bus.req_amount = 5'd3;
         if (bus.done) done_cnt++;
         if (bus.coin_valid) begin
            if (hi == 0) begin
               coin_log.push_back(bus.coin_sel);
               if (seen && lo < min_gap) min_gap = lo;
               seen = 1'b1;
               lo = 0;
            end
            hi++;
            hi_total++;
            bus.hopper_ack = (ack_delay >= 0 && hi >= ack_delay);
         end else begin
            bus.hopper_ack = 1'b0;
            hi = 0;
            lo++;
         end
         if (bus.done || bus.fault) begin
            svc_end = 1'b1;
            break;
         end
      end
      bus.hopper_ack = 1'b0;
      bus.restock    = 1'b0;
      bus.req_valid  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus.req_ready); end
      checks++; if (bus.coin_valid !== 1'b0) begin errors++; $display("FAIL reset_cv: got %0b want 0", bus.coin_valid); end
      checks++; if (bus.coin_sel !== 3'b000) begin errors++; $display("FAIL reset_sel: got %b want 000", bus.coin_sel); end
      checks++; if ({bus.busy, bus.done, bus.fault} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.fault}); end
      checks++; if (bus.remaining !== 5'd0) begin errors++; $display("FAIL reset_rem: got %0d want 0", bus.remaining); end
      checks++; if ({bus.cnt5, bus.cnt2, bus.cnt1} !== {4'd8, 4'd8, 4'd8}) begin errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 8/8/8", bus.cnt5, bus.cnt2, bus.cnt1); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_greedy();
      send_req(5'd8);
      service(2, 200, -1, -1);
      checks++; if (svc_end !== 1'b1) begin errors++; $display("FAIL greedy_end: got %0b want 1 (no done within budget)", svc_end); end
      checks++; if (coin_log.size() != 3) begin errors++; $display("FAIL greedy_ncoins: got %0d want 3", coin_log.size()); end
      else begin
         checks++; if (coin_log[0] !== 3'b100) begin errors++; $display("FAIL greedy_c0: got %b want 100", coin_log[0]); end
         checks++; if (coin_log[1] !== 3'b010) begin errors++; $display("FAIL greedy_c1: got %b want 010", coin_log[1]); end
         checks++; if (coin_log[2] !== 3'b001) begin errors++; $display("FAIL greedy_c2: got %b want 001", coin_log[2]); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL greedy_done: got %0d want 1", done_cnt); end
      checks++; if (min_gap < 4) begin errors++; $display("FAIL greedy_gap: got %0d want >=4", min_gap); end
      checks++; if (bus.remaining !== 5'd0) begin errors++; $display("FAIL greedy_rem: got %0d want 0", bus.remaining); end
      checks++; if ({bus.cnt5, bus.cnt2, bus.cnt1} !== {4'd7, 4'd7, 4'd7}) begin errors++; $display("FAIL greedy_cnt: got %0d/%0d/%0d want 7/7/7", bus.cnt5, bus.cnt2, bus.cnt1); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL greedy_done_pulse: got %0b want 0", bus.done); end
   endtask

   task automatic test_zero();
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_amount = 5'd0;
      @(negedge clk);
      bus.req_valid  = 1'b0;
      checks++; if ({bus.done, bus.req_ready, bus.coin_valid} !== 3'b000) begin errors++; $display("FAIL zero_c1: got done/ready/cv=%b want 000", {bus.done, bus.req_ready, bus.coin_valid}); end
      @(negedge clk);
      checks++; if ({bus.done, bus.busy, bus.coin_valid} !== 3'b100) begin errors++; $display("FAIL zero_c2: got done/busy/cv=%b want 100", {bus.done, bus.busy, bus.coin_valid}); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_c3: got done=%0b want 0", bus.done); end
      checks++; if ({bus.cnt5, bus.cnt2, bus.cnt1} !== {4'd7, 4'd7, 4'd7}) begin errors++; $display("FAIL zero_cnt: got %0d/%0d/%0d want 7/7/7", bus.cnt5, bus.cnt2, bus.cnt1); end
   endtask

   task automatic test_greedy_fault();
      // Restock in IDLE reloads the inventory
      @(negedge clk); bus.restock = 1'b1;
      @(negedge clk); bus.restock = 1'b0;
      checks++; if ({bus.cnt5, bus.cnt2, bus.cnt1} !== {4'd8, 4'd8, 4'd8}) begin errors++; $display("FAIL idle_restock: got %0d/%0d/%0d want 8/8/8", bus.cnt5, bus.cnt2, bus.cnt1); end
      for (int i = 0; i < 8; i++) begin
         send_req(5'd1);
         service(2, 100, -1, -1);
         checks++; if (!svc_end || done_cnt != 1 || coin_log.size() != 1) begin errors++; $display("FAIL drain_%0d: got end=%0b done=%0d coins=%0d want 1/1/1", i, svc_end, done_cnt, coin_log.size()); end
      end
      checks++; if ({bus.cnt5, bus.cnt2, bus.cnt1} !== {4'd8, 4'd8, 4'd0}) begin errors++; $display("FAIL drain_cnt: got %0d/%0d/%0d want 8/8/0", bus.cnt5, bus.cnt2, bus.cnt1); end
      send_req(5'd6);
      service(2, 100, -1, -1);
      checks++; if (coin_log.size() != 1 || done_cnt != 0) begin errors++; $display("FAIL f6_coins: got coins=%0d done=%0d want 1/0", coin_log.size(), done_cnt); end
      else begin
         checks++; if (coin_log[0] !== 3'b100) begin errors++; $display("FAIL f6_c0: got %b want 100", coin_log[0]); end
      end
      checks++; if ({bus.fault, bus.req_ready, bus.busy, bus.coin_valid} !== 4'b1000) begin errors++; $display("FAIL f6_flags: got fault/ready/busy/cv=%b want 1000", {bus.fault, bus.req_ready, bus.busy, bus.coin_valid}); end
      checks++; if (bus.remaining !== 5'd1) begin errors++; $display("FAIL f6_rem: got %0d want 1", bus.remaining); end
      checks++; if (bus.cnt5 !== 4'd7) begin errors++; $display("FAIL f6_cnt5: got %0d want 7", bus.cnt5); end
      // A request while faulted is ignored
      @(negedge clk); bus.req_valid = 1'b1; bus.req_amount = 5'd4;
      repeat (2) @(negedge clk);
      bus.req_valid = 1'b0;
      checks++; if ({bus.fault, bus.remaining, bus.coin_valid} !== {1'b1, 5'd1, 1'b0}) begin errors++; $display("FAIL f6_ignore: got fault=%0b rem=%0d cv=%0b want 1/1/0", bus.fault, bus.remaining, bus.coin_valid); end
      @(negedge clk); bus.restock = 1'b1;
      @(negedge clk); bus.restock = 1'b0;
      checks++; if ({bus.fault, bus.req_ready, bus.remaining} !== {1'b0, 1'b1, 5'd0}) begin errors++; $display("FAIL f6_restock: got fault=%0b ready=%0b rem=%0d want 0/1/0", bus.fault, bus.req_ready, bus.remaining); end
      checks++; if ({bus.cnt5, bus.cnt2, bus.cnt1} !== {4'd8, 4'd8, 4'd8}) begin errors++; $display("FAIL f6_cnt: got %0d/%0d/%0d want 8/8/8", bus.cnt5, bus.cnt2, bus.cnt1); end
   endtask

   task automatic test_timeout();
      send_req(5'd2);
      service(-1, 400, -1, -1);
      checks++; if (svc_end !== 1'b1) begin errors++; $display("FAIL to_end: got %0b want 1 (no fault within budget)", svc_end); end
      checks++; if (hi_total != 255) begin errors++; $display("FAIL to_cycles: got %0d want 255", hi_total); end
      checks++; if ({bus.fault, bus.coin_valid, bus.coin_sel} !== {1'b1, 1'b0, 3'b000}) begin errors++; $display("FAIL to_flags: got fault=%0b cv=%0b sel=%b want 1/0/000", bus.fault, bus.coin_valid, bus.coin_sel); end
      checks++; if (bus.remaining !== 5'd2) begin errors++; $display("FAIL to_rem: got %0d want 2", bus.remaining); end
      checks++; if (bus.cnt2 !== 4'd8) begin errors++; $display("FAIL to_cnt2: got %0d want 8", bus.cnt2); end
      @(negedge clk); bus.restock = 1'b1;
      @(negedge clk); bus.restock = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      send_req(5'd10);
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (bus.coin_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      bus.hopper_ack = 1'b1;
      @(negedge clk);
      bus.hopper_ack = 1'b0;
      for (int c = 0; c < 50 && ok; c++) begin
         @(negedge clk);
         if (bus.coin_valid) break;
         if (c == 49) ok = 1'b0;
      end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rm_wait: got %0b want 1 (second coin not presented)", ok); end
      checks++; if (bus.cnt5 !== 4'd7) begin errors++; $display("FAIL rm_pre_cnt5: got %0d want 7", bus.cnt5); end
      #2 reset = 1'b1;
      #1;
      checks++; if ({bus.coin_valid, bus.busy, bus.coin_sel} !== {1'b0, 1'b0, 3'b000}) begin errors++; $display("FAIL rm_async: got cv=%0b busy=%0b sel=%b want 0/0/000", bus.coin_valid, bus.busy, bus.coin_sel); end
      checks++; if (bus.remaining !== 5'd0) begin errors++; $display("FAIL rm_rem: got %0d want 0", bus.remaining); end
      checks++; if ({bus.cnt5, bus.cnt2, bus.cnt1} !== {4'd8, 4'd8, 4'd8}) begin errors++; $display("FAIL rm_cnt: got %0d/%0d/%0d want 8/8/8", bus.cnt5, bus.cnt2, bus.cnt1); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int extra_done;
      bit extra_busy;
      send_req(5'd7);
      service(2, 200, 3, 8);
      checks++; if (!svc_end || done_cnt != 1) begin errors++; $display("FAIL b2b_done: got end=%0b done=%0d want 1/1", svc_end, done_cnt); end
      checks++; if (coin_log.size() != 2) begin errors++; $display("FAIL b2b_ncoins: got %0d want 2", coin_log.size()); end
      else begin
         checks++; if ({coin_log[0], coin_log[1]} !== 6'b100_010) begin errors++; $display("FAIL b2b_order: got %b,%b want 100,010", coin_log[0], coin_log[1]); end
      end
      checks++; if ({bus.cnt5, bus.cnt2, bus.cnt1} !== {4'd7, 4'd7, 4'd8}) begin errors++; $display("FAIL b2b_cnt: got %0d/%0d/%0d want 7/7/8", bus.cnt5, bus.cnt2, bus.cnt1); end
      extra_done = 0;
      extra_busy = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.done) extra_done++;
         if (bus.busy || bus.coin_valid) extra_busy = 1'b1;
      end
      checks++; if (extra_done != 0 || extra_busy !== 1'b0) begin errors++; $display("FAIL b2b_no_queue: got done=%0d active=%0b want 0/0", extra_done, extra_busy); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_amount = '0;
      bus.hopper_ack = 1'b0;
      bus.restock    = 1'b0;
      test_reset();
      test_greedy();
      test_zero();
      test_greedy_fault();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
